// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window scheduler and its
// address helper.
package sobel_pkg;
  localparam int IMG_W_DEF  = 32;
  localparam int IMG_H_DEF  = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int PIX_W_DEF  = 4;
  localparam int TAPS       = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/sobel_win_addr.sv
// Maps a centre pixel (row, col) and a window tap k (0..8, row-major) to a
// frame-memory address, and flags centres lying on the frame edge.
module sobel_win_addr #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int RW     = 5,
  parameter int CW     = 5
) (
  input  logic [RW-1:0]     row,
  input  logic [CW-1:0]     col,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic              border
);
  logic [1:0]        dr;
  logic [1:0]        dc;
  logic [ADDR_W-1:0] r_tap;
  logic [ADDR_W-1:0] c_tap;

  always_comb begin
    dr = 2'd0;
    dc = 2'd0;
    case (k)
      4'd1: dc = 2'd1;
      4'd2: dc = 2'd2;
      4'd3: dr = 2'd1;
      4'd4: begin dr = 2'd1; dc = 2'd1; end
      4'd5: begin dr = 2'd1; dc = 2'd2; end
      4'd6: dr = 2'd2;
      4'd7: begin dr = 2'd2; dc = 2'd1; end
      4'd8: begin dr = 2'd2; dc = 2'd2; end
      default: ;
    endcase
    // Offsets are -1..+1 around the centre; border centres may wrap, but
    // no read is ever issued for them.
    r_tap  = ADDR_W'(row) + ADDR_W'(dr) - ADDR_W'(1);
    c_tap  = ADDR_W'(col) + ADDR_W'(dc) - ADDR_W'(1);
    addr   = r_tap * ADDR_W'(IMG_W) + c_tap;
    border = (row == '0) || (row == RW'(IMG_H - 1)) ||
             (col == '0) || (col == CW'(IMG_W - 1));
  end
endmodule

// File: rtl/sobel_win_sched.sv
// Walks the frame in raster order, fetches each interior 3x3 neighbourhood
// from the grayscale memory and presents it to the Sobel datapath.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing tap k read, capturing tap k-1
// DRAIN   | capturing tap 8, no read
// PRESENT | window valid, waiting for win_ready
// DONE    | one-cycle done pulse
module sobel_win_sched
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    gray_rd_en,
  output logic [ADDR_W-1:0]       gray_rd_addr,
  input  logic [PIX_W-1:0]        gray_rd_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [TAPS*PIX_W-1:0]   win_data,
  output logic [ADDR_W-1:0]       win_addr,
  output logic                    win_border,
  output logic                    busy,
  output logic                    done
);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  state_t                     state;
  logic [RW-1:0]              row, nxt_row, a_row;
  logic [CW-1:0]              col, nxt_col, a_col;
  logic [3:0]                 k, a_k;
  logic [TAPS-1:0][PIX_W-1:0] win;
  logic                       last_col, last_pix;
  logic [ADDR_W-1:0]          tap_addr, ctr_addr;
  logic                       a_border;

  // a_row/a_col always name the pixel whose window comes next, so the
  // registered read address and border flag are ready on the same edge.
  always_comb begin
    last_col = (col == CW'(IMG_W - 1));
    last_pix = last_col && (row == RW'(IMG_H - 1));
    nxt_col  = last_col ? '0 : col + CW'(1);
    nxt_row  = last_col ? row + RW'(1) : row;
    a_row    = row;
    a_col    = col;
    a_k      = 4'd0;
    case (state)
      ST_IDLE:    begin a_row = '0; a_col = '0; end
      ST_FETCH:   a_k = k + 4'd1;
      ST_PRESENT: begin a_row = nxt_row; a_col = nxt_col; end
      default: ;
    endcase
    ctr_addr = ADDR_W'(a_row) * ADDR_W'(IMG_W) + ADDR_W'(a_col);
  end

  sobel_win_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .RW    (RW),
    .CW    (CW)
  ) u_addr (
    .row   (a_row),
    .col   (a_col),
    .k     (a_k),
    .addr  (tap_addr),
    .border(a_border)
  );

  assign win_data = win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      row          <= '0;
      col          <= '0;
      k            <= '0;
      win          <= '0;
      gray_rd_en   <= 1'b0;
      gray_rd_addr <= '0;
      win_valid    <= 1'b0;
      win_addr     <= '0;
      win_border   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            row  <= '0;
            col  <= '0;
            k    <= '0;
            busy <= 1'b1;
            if (a_border) begin
              state      <= ST_PRESENT;
              win_valid  <= 1'b1;
              win_border <= 1'b1;
              win_addr   <= ctr_addr;
              win        <= '0;
            end else begin
              state        <= ST_FETCH;
              gray_rd_en   <= 1'b1;
              gray_rd_addr <= tap_addr;
            end
          end
        end
        ST_FETCH: begin
          if (k != 4'd0) win[k - 4'd1] <= gray_rd_data;
          if (k == 4'd8) begin
            state      <= ST_DRAIN;
            gray_rd_en <= 1'b0;
          end else begin
            k            <= k + 4'd1;
            gray_rd_addr <= tap_addr;
          end
        end
        ST_DRAIN: begin
          win[8]     <= gray_rd_data;
          state      <= ST_PRESENT;
          win_valid  <= 1'b1;
          win_border <= 1'b0;
          win_addr   <= ctr_addr;
        end
        ST_PRESENT: begin
          if (win_ready) begin
            row <= nxt_row;
            col <= nxt_col;
            if (last_pix) begin
              state      <= ST_DONE;
              win_valid  <= 1'b0;
              win_border <= 1'b0;
              done       <= 1'b1;
            end else if (a_border) begin
              win_addr   <= ctr_addr;
              win_border <= 1'b1;
              win        <= '0;
            end else begin
              state        <= ST_FETCH;
              win_valid    <= 1'b0;
              win_border   <= 1'b0;
              k            <= '0;
              gray_rd_en   <= 1'b1;
              gray_rd_addr <= tap_addr;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_win_sched.sv
// Scoreboard bench for sobel_win_sched: a frame model pushes expected reads
// and windows, a negedge monitor pops and compares as the DUT produces them.
module tb_sobel_win_sched;
  import sobel_pkg::*;

  localparam int W = 32, H = 32, AW = 10, PW = 4, NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          gray_rd_en;
  logic [AW-1:0] gray_rd_addr;
  logic [PW-1:0] gray_rd_data;
  logic          win_valid, win_ready;
  logic [9*PW-1:0] win_data;
  logic [AW-1:0] win_addr;
  logic          win_border, busy, done;

  always #5 clk = ~clk;

  sobel_win_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .gray_rd_en(gray_rd_en), .gray_rd_addr(gray_rd_addr), .gray_rd_data(gray_rd_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_addr(win_addr), .win_border(win_border), .busy(busy), .done(done)
  );

  typedef struct {
    int              addr;
    bit              border;
    logic [9*PW-1:0] data;
  } win_t;

  win_t          exp_q[$];
  int            rd_q[$];
  logic [PW-1:0] mem [NPIX];

  int   total = 0, bad = 0;
  int   accepted, border_seen, done_cnt = 0;
  bit   active = 0;
  int   ready_mode = 0;
  int   stall_cnt = 0;
  bit   rd_pend = 0;
  logic [AW-1:0] rd_pend_addr = '0;
  bit   chk34 = 0;
  bit   prev_stall = 0;
  logic [9*PW-1:0] prev_data;
  logic [AW-1:0]   prev_addr;
  logic            prev_border;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Expected behaviour of a whole frame, straight from the raster/3x3 rules.
  function automatic void build_model();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        win_t w;
        w.addr   = r * W + c;
        w.border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        w.data   = '0;
        if (!w.border) begin
          for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
              int a;
              a = (r + dy - 1) * W + (c + dx - 1);
              w.data[(dy * 3 + dx) * PW +: PW] = mem[a];
              rd_q.push_back(a);
            end
          end
        end
        exp_q.push_back(w);
      end
    end
  endfunction

  // Memory (1-cycle latency) and win_ready driver.
  initial begin
    win_ready    = 1'b1;
    gray_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      gray_rd_data = rd_pend ? mem[rd_pend_addr] : '0;
      case (ready_mode)
        1: win_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (win_valid && win_addr == AW'(33) && stall_cnt < 5) begin
            win_ready = 1'b0;
            stall_cnt++;
          end else begin
            win_ready = 1'b1;
          end
        end
        default: win_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    rd_pend      = gray_rd_en;
    rd_pend_addr = gray_rd_addr;
    if (rst && active) begin
      if (chk34) begin
        chk("fetch34_rd_en", 64'(gray_rd_en), 64'd1);
        chk("fetch34_addr", 64'(gray_rd_addr), 64'd1);
        chk34 = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(win_valid), 64'd1);
        chk("stall_data", 64'(win_data), 64'(prev_data));
        chk("stall_addr", 64'(win_addr), 64'(prev_addr));
        chk("stall_border", 64'(win_border), 64'(prev_border));
      end
      if (win_valid) chk("rd_in_present", 64'(gray_rd_en), 64'd0);
      if (gray_rd_en) begin
        if (rd_q.size() == 0) fail_now("rd_extra");
        else chk("rd_addr", 64'(gray_rd_addr), 64'(rd_q.pop_front()));
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) fail_now("win_extra");
        else begin
          win_t w;
          w = exp_q.pop_front();
          chk("win_addr", 64'(win_addr), 64'(w.addr));
          chk("win_border", 64'(win_border), 64'(w.border));
          chk("win_data", 64'(win_data), 64'(w.data));
        end
        accepted++;
        if (win_border) border_seen++;
        if (ready_mode == 2 && win_addr == AW'(33)) chk34 = 1;
      end
      prev_stall  = win_valid && !win_ready;
      prev_data   = win_data;
      prev_addr   = win_addr;
      prev_border = win_border;
      if (done) done_cnt++;
    end
  end

  task automatic prep(input int mode);
    ready_mode  = mode;
    stall_cnt   = 0;
    accepted    = 0;
    border_seen = 0;
    prev_stall  = 0;
    chk34       = 0;
    exp_q.delete();
    rd_q.delete();
    build_model();
    active = 1;
  endtask

  task automatic run_frame(input int mode, input int exp_cycles, input bit glitch);
    int n, d0;
    bit got, glitched;
    prep(mode);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0; got = 0; glitched = 0;
    while (!got && n < 20000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk("first_busy", 64'(busy), 64'd1);
        chk("first_valid", 64'(win_valid), 64'd1);
        chk("first_border", 64'(win_border), 64'd1);
        chk("first_addr", 64'(win_addr), 64'd0);
        chk("first_data", 64'(win_data), 64'd0);
      end else if (start) begin
        start = 1'b0;
      end
      if (glitch && !glitched && gray_rd_en) begin
        start    = 1'b1;
        glitched = 1;
      end
      if (done) got = 1;
    end
    if (!got) fail_now("frame_timeout");
    else if (exp_cycles > 0) chk("frame_cycles", 64'(n), 64'(exp_cycles));
    if (glitch && got) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("valid_after_done", 64'(win_valid), 64'd0);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rd_en", 64'(gray_rd_en), 64'd0);
    chk("accepted", 64'(accepted), 64'(NPIX));
    chk("borders", 64'(border_seen), 64'd124);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("win_q_left", 64'(exp_q.size()), 64'd0);
    chk("rd_q_left", 64'(rd_q.size()), 64'd0);
    active = 0;
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < NPIX; a++) mem[a] = PW'($urandom);
  endtask

  initial begin
    int  n;
    bit  hit, saw_done;
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 64'(gray_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(gray_rd_addr), 64'd0);
    chk("rst_valid", 64'(win_valid), 64'd0);
    chk("rst_data", 64'(win_data), 64'd0);
    chk("rst_win_addr", 64'(win_addr), 64'd0);
    chk("rst_border", 64'(win_border), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);

    for (int a = 0; a < NPIX; a++) mem[a] = PW'(a);
    run_frame(2, 10030, 0);

    randomize_mem();
    run_frame(0, 10025, 1);

    randomize_mem();
    run_frame(1, -1, 0);

    // Abandon a frame during tap 4 of window 500.
    randomize_mem();
    prep(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; hit = 0;
    while (!hit && n < 20000) begin
      @(negedge clk);
      n++;
      if (gray_rd_en && gray_rd_addr == AW'(500) && accepted == 500) hit = 1;
    end
    if (!hit) fail_now("midframe_timeout");
    #2 rst = 1'b0;
    active = 0;
    #1;
    chk("mid_rst_rd_en", 64'(gray_rd_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(win_valid), 64'd0);
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("mid_rst_no_done", 64'(saw_done), 64'd0);
    chk("mid_rst_idle", 64'(busy), 64'd0);

    randomize_mem();
    run_frame(1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
